// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared definitions for the hardwired control unit that drives DataPath:
// FSM state encoding, instruction opcodes, ALU operation selects, the bit
// position of every strobe inside the 32-bit ctrl bundle, and a small
// opcode classifier shared by the decoder and the sequencer.
package cpu_ctrl_pkg;

    // One fetch/execute step per state; RESET_S and HALT_S are idle states.
    typedef enum logic [3:0] {
        RESET_S = 4'd0,
        T0      = 4'd1,
        T1      = 4'd2,
        T2      = 4'd3,
        T3      = 4'd4,
        T4      = 4'd5,
        T5      = 4'd6,
        T6      = 4'd7,
        T7      = 4'd8,
        HALT_S  = 4'd9
    } state_t;

    // Instruction families that share an execute sequence.
    typedef enum logic [2:0] {
        CLS_LD,
        CLS_LDI,
        CLS_ST,
        CLS_ALU,
        CLS_ALUI,
        CLS_BR,
        CLS_HALT,
        CLS_NOP
    } instr_class_t;

    // Opcodes, ir[31:27].
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // ALU selects share the encoding of the matching register opcode.
    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_AND = 5'b00101;
    localparam logic [4:0] ALU_OR  = 5'b00110;

    // Strobe positions inside ctrl; bits 31:20 are unused and stay 0.
    localparam int CTRL_PCOUT   = 0;
    localparam int CTRL_MARIN   = 1;
    localparam int CTRL_INCPC   = 2;
    localparam int CTRL_ZIN     = 3;
    localparam int CTRL_ZLOWOUT = 4;
    localparam int CTRL_PCIN    = 5;
    localparam int CTRL_READ    = 6;
    localparam int CTRL_WRITE   = 7;
    localparam int CTRL_MDRIN   = 8;
    localparam int CTRL_MDROUT  = 9;
    localparam int CTRL_IRIN    = 10;
    localparam int CTRL_GRA     = 11;
    localparam int CTRL_GRB     = 12;
    localparam int CTRL_GRC     = 13;
    localparam int CTRL_RIN     = 14;
    localparam int CTRL_ROUT    = 15;
    localparam int CTRL_BAOUT   = 16;
    localparam int CTRL_COUT    = 17;
    localparam int CTRL_YIN     = 18;
    localparam int CTRL_CONIN   = 19;

    // Map an opcode to its execute family; anything unknown behaves as nop.
    function automatic instr_class_t classify(input logic [4:0] op);
        case (op)
            OP_LD:   return CLS_LD;
            OP_LDI:  return CLS_LDI;
            OP_ST:   return CLS_ST;
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL:
                     return CLS_ALU;
            OP_ADDI, OP_ANDI, OP_ORI:
                     return CLS_ALUI;
            OP_BR:   return CLS_BR;
            OP_HALT: return CLS_HALT;
            default: return CLS_NOP;
        endcase
    endfunction

    // ALU operation used by an immediate-form instruction.
    function automatic logic [4:0] imm_alu_op(input logic [4:0] op);
        case (op)
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode
// Purely combinational strobe decoder: turns the current sequencer state,
// the instruction opcode and the branch condition into the DataPath strobe
// bundle and the ALU operation select. Strobes not named for a step are 0.
//
// Ports:
//   state   in   current sequencer state
//   opcode  in   ir[31:27]
//   con_ff  in   branch condition flip-flop (used only in the branch T6 step)
//   ctrl    out  32-bit strobe bundle, bit positions from cpu_ctrl_pkg
//   ops     out  ALU operation select
module ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW = 5
) (
    input  state_t           state,
    input  logic [4:0]       opcode,
    input  logic             con_ff,
    output logic [31:0]      ctrl,
    output logic [OPW-1:0]   ops
);

    instr_class_t cls;
    logic [4:0]   alu_sel;

    assign cls = classify(opcode);
    assign ops = OPW'(alu_sel);

    // Strobe table: fetch in T0..T2, family-specific execute steps after.
    always_comb begin
        ctrl    = '0;
        alu_sel = '0;
        case (state)
            T0: begin
                ctrl[CTRL_PCOUT] = 1'b1;
                ctrl[CTRL_MARIN] = 1'b1;
                ctrl[CTRL_INCPC] = 1'b1;
                ctrl[CTRL_ZIN]   = 1'b1;
            end
            T1: begin
                ctrl[CTRL_ZLOWOUT] = 1'b1;
                ctrl[CTRL_PCIN]    = 1'b1;
                ctrl[CTRL_READ]    = 1'b1;
                ctrl[CTRL_MDRIN]   = 1'b1;
            end
            T2: begin
                ctrl[CTRL_MDROUT] = 1'b1;
                ctrl[CTRL_IRIN]   = 1'b1;
            end
            T3: begin
                case (cls)
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        ctrl[CTRL_GRB]   = 1'b1;
                        ctrl[CTRL_BAOUT] = 1'b1;
                        ctrl[CTRL_YIN]   = 1'b1;
                    end
                    CLS_ALU, CLS_ALUI: begin
                        ctrl[CTRL_GRB]  = 1'b1;
                        ctrl[CTRL_ROUT] = 1'b1;
                        ctrl[CTRL_YIN]  = 1'b1;
                    end
                    CLS_BR: begin
                        ctrl[CTRL_GRA]   = 1'b1;
                        ctrl[CTRL_ROUT]  = 1'b1;
                        ctrl[CTRL_CONIN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            T4: begin
                case (cls)
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        ctrl[CTRL_COUT] = 1'b1;
                        ctrl[CTRL_ZIN]  = 1'b1;
                        alu_sel         = ALU_ADD;
                    end
                    CLS_ALU: begin
                        ctrl[CTRL_GRC]  = 1'b1;
                        ctrl[CTRL_ROUT] = 1'b1;
                        ctrl[CTRL_ZIN]  = 1'b1;
                        alu_sel         = opcode;
                    end
                    CLS_ALUI: begin
                        ctrl[CTRL_COUT] = 1'b1;
                        ctrl[CTRL_ZIN]  = 1'b1;
                        alu_sel         = imm_alu_op(opcode);
                    end
                    CLS_BR: begin
                        ctrl[CTRL_PCOUT] = 1'b1;
                        ctrl[CTRL_YIN]   = 1'b1;
                    end
                    default: ;
                endcase
            end
            T5: begin
                case (cls)
                    CLS_LD, CLS_ST: begin
                        ctrl[CTRL_ZLOWOUT] = 1'b1;
                        ctrl[CTRL_MARIN]   = 1'b1;
                    end
                    CLS_LDI, CLS_ALU, CLS_ALUI: begin
                        ctrl[CTRL_ZLOWOUT] = 1'b1;
                        ctrl[CTRL_GRA]     = 1'b1;
                        ctrl[CTRL_RIN]     = 1'b1;
                    end
                    CLS_BR: begin
                        ctrl[CTRL_COUT] = 1'b1;
                        ctrl[CTRL_ZIN]  = 1'b1;
                        alu_sel         = ALU_ADD;
                    end
                    default: ;
                endcase
            end
            T6: begin
                case (cls)
                    CLS_LD: begin
                        ctrl[CTRL_READ]  = 1'b1;
                        ctrl[CTRL_MDRIN] = 1'b1;
                    end
                    // Read stays low so MDR captures the register value on the bus.
                    CLS_ST: begin
                        ctrl[CTRL_GRA]   = 1'b1;
                        ctrl[CTRL_ROUT]  = 1'b1;
                        ctrl[CTRL_MDRIN] = 1'b1;
                    end
                    // CON FF was loaded in T3, so it has settled by now.
                    CLS_BR: begin
                        ctrl[CTRL_ZLOWOUT] = 1'b1;
                        ctrl[CTRL_PCIN]    = con_ff;
                    end
                    default: ;
                endcase
            end
            T7: begin
                case (cls)
                    CLS_LD: begin
                        ctrl[CTRL_MDROUT] = 1'b1;
                        ctrl[CTRL_GRA]    = 1'b1;
                        ctrl[CTRL_RIN]    = 1'b1;
                    end
                    CLS_ST: begin
                        ctrl[CTRL_WRITE] = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer
// Hardwired control unit for DataPath. Fetches, decodes and executes one
// instruction at a time, stalling on the memory ready handshake for every
// Read/Write and flagging a sticky error if memory never answers.
//
// Optional build macro SINGLE_STEP_EN: adds a 'step' input; the sequencer
// then parks in T0 (all strobes low) until a rising edge of step, running
// exactly one instruction per pulse.
//
// Ports:
//   clock      in   system clock, rising edge
//   clear      in   asynchronous active-low reset
//   ir         in   instruction register contents (opcode in ir[31:27])
//   con_ff     in   branch condition flip-flop
//   mem_ready  in   memory finished the current Read/Write
//   step       in   single-step pulse (SINGLE_STEP_EN builds only)
//   ctrl       out  DataPath strobe bundle
//   ops        out  ALU operation select
//   run        out  high while fetching/executing
//   mem_err    out  sticky memory timeout flag
//   state_o    out  current state, for debug
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW      = 5,
    parameter int WAIT_MAX = 15
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [31:0]      ir,
    input  logic             con_ff,
    input  logic             mem_ready,
`ifdef SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic [31:0]      ctrl,
    output logic [OPW-1:0]   ops,
    output logic             run,
    output logic             mem_err,
    output logic [3:0]       state_o
);

    // The counter only needs to reach WAIT_MAX-1; that cycle is the last one.
    localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);

    state_t         state;
    state_t         state_next;
    instr_class_t   cls;
    logic [CW-1:0]  wait_cnt;
    logic           mem_wait;
    logic           timeout;
    logic           mem_done;
    logic           go;
    logic [31:0]    ctrl_raw;
    logic [26:0]    unused_ir_bits;

    assign cls            = classify(ir[31:27]);
    assign unused_ir_bits = ir[26:0];

    // Only the fetch read, the ld data read and the st write handshake with
    // memory; mem_ready in any other state has no effect.
    assign mem_wait = (state == T1)
                   || (state == T6 && cls == CLS_LD)
                   || (state == T7 && cls == CLS_ST);
    assign timeout  = mem_wait && !mem_ready && (wait_cnt == CW'(WAIT_MAX - 1));
    assign mem_done = mem_ready || timeout;

`ifdef SINGLE_STEP_EN
    logic step_prev;
    logic step_armed;

    // Edge detector: a new rising edge arms one instruction, and arming wins
    // over consumption so a pulse landing in the T0 exit cycle is not lost.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            step_prev  <= 1'b0;
            step_armed <= 1'b0;
        end else begin
            step_prev <= step;
            if (step && !step_prev) begin
                step_armed <= 1'b1;
            end else if (state == T0) begin
                step_armed <= 1'b0;
            end
        end
    end

    assign go = step_armed;
`else
    assign go = 1'b1;
`endif

    // State register, wait counter and sticky error flag.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state    <= RESET_S;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state <= state_next;
            if (mem_wait && !mem_ready && !timeout) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (timeout) begin
                mem_err <= 1'b1;
            end
        end
    end

    // Next-state logic; a timeout advances exactly as if memory had answered.
    always_comb begin
        state_next = state;
        case (state)
            RESET_S: state_next = T0;
            T0:      if (go) state_next = T1;
            T1:      if (mem_done) state_next = T2;
            T2: begin
                case (cls)
                    CLS_HALT: state_next = HALT_S;
                    CLS_NOP:  state_next = T0;
                    default:  state_next = T3;
                endcase
            end
            T3:      state_next = T4;
            T4:      state_next = T5;
            T5: begin
                if (cls == CLS_LD || cls == CLS_ST || cls == CLS_BR) begin
                    state_next = T6;
                end else begin
                    state_next = T0;
                end
            end
            T6: begin
                if (cls == CLS_LD) begin
                    if (mem_done) state_next = T7;
                end else if (cls == CLS_ST) begin
                    state_next = T7;
                end else begin
                    state_next = T0;
                end
            end
            T7:      if (!mem_wait || mem_done) state_next = T0;
            HALT_S:  state_next = HALT_S;
            default: state_next = RESET_S;
        endcase
    end

    ctrl_decode #(
        .OPW    (OPW)
    ) u_decode (
        .state  (state),
        .opcode (ir[31:27]),
        .con_ff (con_ff),
        .ctrl   (ctrl_raw),
        .ops    (ops)
    );

    // Output gating: T0 is silent while waiting for a step, and PC must be
    // loaded only once while the fetch read is stalled in T1.
    always_comb begin
        ctrl = ctrl_raw;
        if (state == T0 && !go) begin
            ctrl = '0;
        end else if (state == T1 && wait_cnt != '0) begin
            ctrl[CTRL_PCIN] = 1'b0;
        end
    end

    assign run     = (state != RESET_S) && (state != HALT_S);
    assign state_o = state;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
// Self-checking bench for control_sequencer (default build). A behavioural
// model lists, per instruction, the expected strobe word and ALU select of
// each step; the bench walks the DUT through it with random memory delays,
// random unrelated inputs and a few directed corner cases.
module tb_control_sequencer;
    import cpu_ctrl_pkg::*;

    localparam int WAIT_MAX = 15;

    // Strobe positions, in the order the bundle is documented.
    localparam int B_PCOUT = 0,  B_MARIN = 1,  B_INCPC = 2,  B_ZIN = 3;
    localparam int B_ZLOWOUT = 4, B_PCIN = 5,  B_READ = 6,   B_WRITE = 7;
    localparam int B_MDRIN = 8,  B_MDROUT = 9, B_IRIN = 10,  B_GRA = 11;
    localparam int B_GRB = 12,   B_GRC = 13,   B_RIN = 14,   B_ROUT = 15;
    localparam int B_BAOUT = 16, B_COUT = 17,  B_YIN = 18,   B_CONIN = 19;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] ir;
    logic        con_ff;
    logic        mem_ready;
    logic [31:0] ctrl;
    logic [4:0]  ops;
    logic        run;
    logic        mem_err;
    logic [3:0]  state_o;

    int tests_run    = 0;
    int tests_failed = 0;
    bit err_model    = 1'b0;

    typedef struct {
        state_t      st;
        logic [31:0] ctrl;
        logic [4:0]  ops;
        bit          waitable;
    } step_t;

    step_t exp_q[$];

    always #5 clock = ~clock;

    control_sequencer #(
        .OPW       (5),
        .WAIT_MAX  (WAIT_MAX)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .ir        (ir),
        .con_ff    (con_ff),
        .mem_ready (mem_ready),
        .ctrl      (ctrl),
        .ops       (ops),
        .run       (run),
        .mem_err   (mem_err),
        .state_o   (state_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    function automatic logic [31:0] sb(input int a, input int b = -1,
                                       input int c = -1, input int d = -1);
        logic [31:0] v;
        v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        if (c >= 0) v[c] = 1'b1;
        if (d >= 0) v[d] = 1'b1;
        return v;
    endfunction

    function automatic void push(input state_t st, input logic [31:0] c,
                                 input int o, input bit w);
        step_t s;
        s.st       = st;
        s.ctrl     = c;
        s.ops      = 5'(o);
        s.waitable = w;
        exp_q.push_back(s);
    endfunction

    // Instruction-level model: expected step list straight from the
    // instruction descriptions (halt's HALT_S is checked by its caller).
    function automatic void build_model(input logic [31:0] ir_val, input bit con_val);
        int op;
        op = int'(ir_val[31:27]);
        exp_q.delete();
        push(T0, sb(B_PCOUT, B_MARIN, B_INCPC, B_ZIN), 0, 1'b0);
        push(T1, sb(B_ZLOWOUT, B_PCIN, B_READ, B_MDRIN), 0, 1'b1);
        push(T2, sb(B_MDROUT, B_IRIN), 0, 1'b0);
        if (op <= 2) begin
            push(T3, sb(B_GRB, B_BAOUT, B_YIN), 0, 1'b0);
            push(T4, sb(B_COUT, B_ZIN), 3, 1'b0);
            if (op == 1) begin
                push(T5, sb(B_ZLOWOUT, B_GRA, B_RIN), 0, 1'b0);
            end else begin
                push(T5, sb(B_ZLOWOUT, B_MARIN), 0, 1'b0);
                if (op == 0) begin
                    push(T6, sb(B_READ, B_MDRIN), 0, 1'b1);
                    push(T7, sb(B_MDROUT, B_GRA, B_RIN), 0, 1'b0);
                end else begin
                    push(T6, sb(B_GRA, B_ROUT, B_MDRIN), 0, 1'b0);
                    push(T7, sb(B_WRITE), 0, 1'b1);
                end
            end
        end else if (op <= 13) begin
            push(T3, sb(B_GRB, B_ROUT, B_YIN), 0, 1'b0);
            if (op <= 10) push(T4, sb(B_GRC, B_ROUT, B_ZIN), op, 1'b0);
            else          push(T4, sb(B_COUT, B_ZIN), (op == 11) ? 3 : (op == 12) ? 5 : 6, 1'b0);
            push(T5, sb(B_ZLOWOUT, B_GRA, B_RIN), 0, 1'b0);
        end else if (op == 19) begin
            push(T3, sb(B_GRA, B_ROUT, B_CONIN), 0, 1'b0);
            push(T4, sb(B_PCOUT, B_YIN), 0, 1'b0);
            push(T5, sb(B_COUT, B_ZIN), 3, 1'b0);
            push(T6, con_val ? sb(B_ZLOWOUT, B_PCIN) : sb(B_ZLOWOUT), 0, 1'b0);
        end
    endfunction

    // Walk the DUT through one instruction (or its first max_steps steps).
    // k_t1 / k_mem: number of cycles mem_ready stays low in the fetch read
    // and in the ld/st data access; k >= WAIT_MAX means memory never answers.
    task automatic applyStimulus(input logic [31:0] ir_val, input bit con_val,
                                 input int k_t1, input int k_mem, input int max_steps);
        int n;
        build_model(ir_val, con_val);
        n = (max_steps < 0) ? exp_q.size() : max_steps;
        for (int i = 0; i < n; i++) begin
            int k;
            int dur;
            bit to;
            logic [31:0] exp_c;
            k   = (exp_q[i].st == T1) ? k_t1 : k_mem;
            dur = 1;
            to  = 1'b0;
            if (exp_q[i].waitable) begin
                if (k < WAIT_MAX) dur = k + 1;
                else begin
                    dur = WAIT_MAX;
                    to  = 1'b1;
                end
            end
            for (int c = 0; c < dur; c++) begin
                @(negedge clock);
                if (i == 0 && c == 0) ir = ir_val;
                mem_ready = exp_q[i].waitable ? (c >= k) : 1'($urandom_range(0, 1));
                con_ff    = (exp_q[i].st == T6) ? con_val : 1'($urandom_range(0, 1));
                #1;
                exp_c = exp_q[i].ctrl;
                if (exp_q[i].st == T1 && c > 0) exp_c[B_PCIN] = 1'b0;
                checkOutput($sformatf("state op%0d step%0d", ir_val[31:27], i),
                            32'(state_o), 32'(exp_q[i].st));
                checkOutput($sformatf("ctrl op%0d step%0d", ir_val[31:27], i), ctrl, exp_c);
                checkOutput($sformatf("ops op%0d step%0d", ir_val[31:27], i),
                            32'(ops), 32'(exp_q[i].ops));
                checkOutput("run", 32'(run), 32'd1);
                checkOutput("mem_err", 32'(mem_err), 32'(err_model));
            end
            if (to) err_model = 1'b1;
        end
    endtask

    // Pulse clear low mid-cycle; the idle outputs must appear at once.
    task automatic reset_pulse();
        clear = 1'b0;
        #1;
        err_model = 1'b0;
        checkOutput("reset state", 32'(state_o), 32'(RESET_S));
        checkOutput("reset ctrl", ctrl, 32'd0);
        checkOutput("reset ops", 32'(ops), 32'd0);
        checkOutput("reset run", 32'(run), 32'd0);
        checkOutput("reset mem_err", 32'(mem_err), 32'd0);
        @(negedge clock);
        clear = 1'b1;
        #1;
        checkOutput("post-reset state", 32'(state_o), 32'(RESET_S));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] r_ir;
        int          op;
        clear     = 1'b0;
        ir        = 32'h0;
        con_ff    = 1'b0;
        mem_ready = 1'b0;
        #12;
        reset_pulse();

        // ld r1,0x55(r2) and add r3,r4,r5 with zero wait states.
        applyStimulus(32'h00900055, 1'b0, 0, 0, -1);
        applyStimulus(32'h19A28000, 1'b0, 0, 0, -1);

        // st with three wait states in T7, then br taken and not taken.
        applyStimulus({OP_ST, 27'h0123456}, 1'b0, 1, 3, -1);
        applyStimulus({OP_BR, 27'h0400010}, 1'b1, 0, 0, -1);
        applyStimulus({OP_BR, 27'h0400010}, 1'b0, 2, 0, -1);

        // Random instruction mix including nop/undefined, random delays
        // that always stay below the timeout.
        for (int n = 0; n < 70; n++) begin
            op = int'($urandom_range(0, 31));
            if (op == 27) op = 26;
            r_ir = {5'(op), 27'($urandom)};
            applyStimulus(r_ir, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 14)) : int'($urandom_range(0, 2)),
                          ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 14)) : int'($urandom_range(0, 2)),
                          -1);
        end

        // Memory stuck low during a store: timeout after WAIT_MAX cycles,
        // sticky error persists through the next instruction.
        applyStimulus({OP_ST, 27'h0000040}, 1'b0, 0, 1000, -1);
        applyStimulus({OP_ADDI, 27'h0000007}, 1'b0, 0, 0, -1);
        applyStimulus({OP_LD, 27'h0000001}, 1'b0, 14, 14, -1);

        // clear during T5 of ld, then a full ld from a fresh fetch.
        applyStimulus(32'h00900055, 1'b0, 0, 0, 6);
        reset_pulse();
        applyStimulus(32'h00900055, 1'b0, 0, 0, -1);

        // halt parks the sequencer until clear.
        applyStimulus(32'hD8000000, 1'b0, 1, 0, -1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            checkOutput("halt state", 32'(state_o), 32'(HALT_S));
            checkOutput("halt run", 32'(run), 32'd0);
            checkOutput("halt ctrl", ctrl, 32'd0);
        end
        reset_pulse();
        applyStimulus({OP_ORI, 27'h1234567}, 1'b0, 0, 0, -1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
